idwt_haar: RTL and testbench

- Inverse 2-D Haar reconstruction; the receiving end of the forward DWT_Haar stage.
- Accepts one coefficient set (cA, cH, cV, cD for R, G and B) per handshake. The stream is column-pair-major: outer loop col 0..WIDTH/2-1, inner loop row 0,2,..,HEIGHT-2.
- Each set is rebuilt into two output beats: row r, then row r+1. Each beat carries the even/odd pixel pair at that row and column pair.
- Feeds the image writer: HSYNC qualifies pixel data, frame_done marks frame end.

---
 rtl/idwt_haar_pkg.sv | 16 +
 rtl/idwt_haar_bfly.sv | 20 ++
 rtl/idwt_haar.sv | 194 +++++++++++++++++++
 tb/tb_idwt_haar.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idwt_haar_pkg.sv
// Shared types and widths for the inverse 2-D Haar reconstruction block.
package idwt_haar_pkg;

   localparam int unsigned PIX_W      = 8;
   localparam int unsigned ROW_W      = 9;
   localparam int unsigned COL_W      = 8;
   localparam int unsigned COEF_W_DEF = 10;
   localparam int unsigned NCH        = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_t;

endpackage

// File: rtl/idwt_haar_bfly.sv
// Signed Haar butterfly: (a,b) -> ((a+b)>>>1, (a-b)>>>1), sums one bit wider than the operands.
module idwt_haar_bfly #(
   parameter int unsigned W = 10
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W:0]   sum_o,
   output logic signed [W:0]   dif_o
);

   logic signed [W:0] sum_w;
   logic signed [W:0] dif_w;

   assign sum_w = {a_i[W-1], a_i} + {b_i[W-1], b_i};
   assign dif_w = {a_i[W-1], a_i} - {b_i[W-1], b_i};

   assign sum_o = sum_w >>> 1;
   assign dif_o = dif_w >>> 1;

endmodule

// File: rtl/idwt_haar.sv
// Inverse 2-D Haar: one coefficient set in, two pixel-pair beats out (rows r, r+1).
// Build option: define IDWT_SAT_EN to clamp results to [0,255]; otherwise the low 8 bits are kept.
module idwt_haar
   import idwt_haar_pkg::*;
#(
   parameter int unsigned WIDTH  = 20,
   parameter int unsigned HEIGHT = 30,
   parameter int unsigned COEF_W = COEF_W_DEF
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [COEF_W-1:0]   DATA_R_cA,
   input  logic [COEF_W-1:0]   DATA_G_cA,
   input  logic [COEF_W-1:0]   DATA_B_cA,
   input  logic [COEF_W-1:0]   DATA_R_cH,
   input  logic [COEF_W-1:0]   DATA_G_cH,
   input  logic [COEF_W-1:0]   DATA_B_cH,
   input  logic [COEF_W-1:0]   DATA_R_cV,
   input  logic [COEF_W-1:0]   DATA_G_cV,
   input  logic [COEF_W-1:0]   DATA_B_cV,
   input  logic [COEF_W-1:0]   DATA_R_cD,
   input  logic [COEF_W-1:0]   DATA_G_cD,
   input  logic [COEF_W-1:0]   DATA_B_cD,
   input  logic                out_ready,
   output logic                HSYNC,
   output logic [PIX_W-1:0]    DATA_R_E,
   output logic [PIX_W-1:0]    DATA_G_E,
   output logic [PIX_W-1:0]    DATA_B_E,
   output logic [PIX_W-1:0]    DATA_R_O,
   output logic [PIX_W-1:0]    DATA_G_O,
   output logic [PIX_W-1:0]    DATA_B_O,
   output logic [ROW_W-1:0]    out_row,
   output logic [COL_W-1:0]    out_col,
   output logic                frame_done
);

   localparam int unsigned LW   = COEF_W + 1;
   localparam int unsigned RW   = COEF_W + 2;
   localparam int unsigned RP_W = ROW_W - 1;
   localparam logic [RP_W-1:0]  RP_LAST  = RP_W'(HEIGHT / 2 - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH / 2 - 1);

`ifdef IDWT_SAT_EN
   localparam logic signed [RW-1:0] PIX_MAX = RW'(255);

   function automatic logic [PIX_W-1:0] narrow(input logic signed [RW-1:0] v);
      if (v[RW-1]) return '0;
      if (v > PIX_MAX) return '1;
      return PIX_W'(v);
   endfunction
`else
   function automatic logic [PIX_W-1:0] narrow(input logic signed [RW-1:0] v);
      return PIX_W'(v);
   endfunction
`endif

   state_t            state_q, state_d;
   logic [RP_W-1:0]   rowpair_q, rowpair_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              frame_done_q, frame_done_d;
   logic              accept_w;

   logic signed [COEF_W-1:0] ca_w [NCH];
   logic signed [COEF_W-1:0] ch_w [NCH];
   logic signed [COEF_W-1:0] cv_w [NCH];
   logic signed [COEF_W-1:0] cd_w [NCH];
   logic signed [LW-1:0]     l0_w [NCH], l1_w [NCH], h0_w [NCH], h1_w [NCH];
   logic signed [LW-1:0]     l0_q [NCH], l1_q [NCH], h0_q [NCH], h1_q [NCH];
   logic signed [LW-1:0]     lsel_w [NCH], hsel_w [NCH];
   logic signed [RW-1:0]     e_w [NCH], o_w [NCH];
   logic [PIX_W-1:0]         e_pix [NCH], o_pix [NCH];

   assign ca_w[0] = DATA_R_cA;
   assign ca_w[1] = DATA_G_cA;
   assign ca_w[2] = DATA_B_cA;
   assign ch_w[0] = DATA_R_cH;
   assign ch_w[1] = DATA_G_cH;
   assign ch_w[2] = DATA_B_cH;
   assign cv_w[0] = DATA_R_cV;
   assign cv_w[1] = DATA_G_cV;
   assign cv_w[2] = DATA_B_cV;
   assign cd_w[0] = DATA_R_cD;
   assign cd_w[1] = DATA_G_cD;
   assign cd_w[2] = DATA_B_cD;

   // Column stage ahead of the holding registers, row stage muxed by beat behind them.
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      idwt_haar_bfly #(.W(COEF_W)) u_col_l (
         .a_i   (ca_w[c]),
         .b_i   (ch_w[c]),
         .sum_o (l0_w[c]),
         .dif_o (l1_w[c])
      );

      idwt_haar_bfly #(.W(COEF_W)) u_col_h (
         .a_i   (cv_w[c]),
         .b_i   (cd_w[c]),
         .sum_o (h0_w[c]),
         .dif_o (h1_w[c])
      );

      assign lsel_w[c] = (state_q == BEAT1) ? l1_q[c] : l0_q[c];
      assign hsel_w[c] = (state_q == BEAT1) ? h1_q[c] : h0_q[c];

      idwt_haar_bfly #(.W(LW)) u_row (
         .a_i   (lsel_w[c]),
         .b_i   (hsel_w[c]),
         .sum_o (e_w[c]),
         .dif_o (o_w[c])
      );

      assign e_pix[c] = narrow(e_w[c]);
      assign o_pix[c] = narrow(o_w[c]);
   end

   // A new set may enter while idle or as the second beat of the held set drains.
   assign in_ready = HRESETn & ((state_q == IDLE) | ((state_q == BEAT1) & out_ready));
   assign accept_w = in_valid & in_ready;

   assign HSYNC      = (state_q != IDLE);
   assign out_row    = {rowpair_q, state_q == BEAT1};
   assign out_col    = col_q;
   assign frame_done = frame_done_q;

   assign DATA_R_E = e_pix[0];
   assign DATA_G_E = e_pix[1];
   assign DATA_B_E = e_pix[2];
   assign DATA_R_O = o_pix[0];
   assign DATA_G_O = o_pix[1];
   assign DATA_B_O = o_pix[2];

   always_comb begin
      state_d      = state_q;
      rowpair_d    = rowpair_q;
      col_d        = col_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_w) state_d = BEAT0;
         end
         BEAT0: begin
            if (out_ready) state_d = BEAT1;
         end
         BEAT1: begin
            if (out_ready) begin
               state_d = in_valid ? BEAT0 : IDLE;
               if (rowpair_q == RP_LAST) begin
                  rowpair_d = '0;
                  if (col_q == COL_LAST) begin
                     col_d        = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
               end else begin
                  rowpair_d = rowpair_q + RP_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= IDLE;
         rowpair_q    <= '0;
         col_q        <= '0;
         frame_done_q <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            l0_q[c] <= '0;
            l1_q[c] <= '0;
            h0_q[c] <= '0;
            h1_q[c] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rowpair_q    <= rowpair_d;
         col_q        <= col_d;
         frame_done_q <= frame_done_d;
         if (accept_w) begin
            for (int c = 0; c < NCH; c++) begin
               l0_q[c] <= l0_w[c];
               l1_q[c] <= l1_w[c];
               h0_q[c] <= h0_w[c];
               h1_q[c] <= h1_w[c];
            end
         end
      end
   end

endmodule

// File: tb/tb_idwt_haar.sv
// Self-checking bench for idwt_haar: vector table, directed sequences and a randomized scoreboard.
module tb_idwt_haar;

   localparam int unsigned CW = 10;
   localparam int unsigned W  = 4;
   localparam int unsigned H  = 4;
`ifdef IDWT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [CW-1:0] cA [3];
   logic [CW-1:0] cH [3];
   logic [CW-1:0] cV [3];
   logic [CW-1:0] cD [3];
   logic in_ready, HSYNC, frame_done;
   logic [7:0] pe [3];
   logic [7:0] po [3];
   logic [8:0] out_row;
   logic [7:0] out_col;

   always #5 HCLK = ~HCLK;

   idwt_haar #(.WIDTH(W), .HEIGHT(H), .COEF_W(CW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .in_ready(in_ready),
      .DATA_R_cA(cA[0]), .DATA_G_cA(cA[1]), .DATA_B_cA(cA[2]),
      .DATA_R_cH(cH[0]), .DATA_G_cH(cH[1]), .DATA_B_cH(cH[2]),
      .DATA_R_cV(cV[0]), .DATA_G_cV(cV[1]), .DATA_B_cV(cV[2]),
      .DATA_R_cD(cD[0]), .DATA_G_cD(cD[1]), .DATA_B_cD(cD[2]),
      .out_ready(out_ready), .HSYNC(HSYNC),
      .DATA_R_E(pe[0]), .DATA_G_E(pe[1]), .DATA_B_E(pe[2]),
      .DATA_R_O(po[0]), .DATA_G_O(po[1]), .DATA_B_O(po[2]),
      .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the reconstruction formulas.
   function automatic int narrow(input int v);
      if (SAT) return (v < 0) ? 0 : ((v > 255) ? 255 : v);
      return v & 255;
   endfunction

   typedef struct packed {
      logic [47:0] pix;   // {E_r,E_g,E_b,O_r,O_g,O_b}
      logic [8:0]  row;
      logic [7:0]  col;
      logic        second;
      logic        last;
   } beat_t;

   beat_t q[$];
   int    s_acc   = 0;
   bit    fd_next = 1'b0;

   function automatic logic [47:0] dut_pix();
      return {pe[0], pe[1], pe[2], po[0], po[1], po[2]};
   endfunction

   always @(negedge HCLK) begin : mon
      beat_t b;
      int a, h, v, d, l, hh, sp, col;
      logic [7:0] ev [3];
      logic [7:0] ov [3];
      if (!HRESETn) begin
         chk("rst_hsync", HSYNC, 0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_pos", {out_row, out_col}, 0);
         chk("rst_frame_done", frame_done, 0);
         chk("rst_pix", dut_pix(), 0);
         q.delete();
         s_acc   = 0;
         fd_next = 1'b0;
      end else begin
         if (frame_done || fd_next) chk("frame_done", frame_done, fd_next);
         fd_next = 1'b0;
         chk("hsync", HSYNC, q.size() != 0);
         if (HSYNC && q.size() != 0) begin
            b = q[0];
            chk("beat_pix", dut_pix(), b.pix);
            chk("beat_pos", {out_row, out_col}, {b.row, b.col});
            chk("beat_in_ready", in_ready, b.second & out_ready);
            if (out_ready) begin
               void'(q.pop_front());
               fd_next = b.last;
            end
         end else if (!HSYNC) begin
            chk("idle_in_ready", in_ready, 1);
         end
         if (in_valid && in_ready) begin
            sp  = s_acc % (H / 2);
            col = (s_acc / (H / 2)) % (W / 2);
            for (int sec = 0; sec < 2; sec++) begin
               for (int c = 0; c < 3; c++) begin
                  a = $signed(cA[c]); h = $signed(cH[c]);
                  v = $signed(cV[c]); d = $signed(cD[c]);
                  l  = (sec == 1) ? (a - h) >>> 1 : (a + h) >>> 1;
                  hh = (sec == 1) ? (v - d) >>> 1 : (v + d) >>> 1;
                  ev[c] = 8'(narrow((l + hh) >>> 1));
                  ov[c] = 8'(narrow((l - hh) >>> 1));
               end
               b.pix    = {ev[0], ev[1], ev[2], ov[0], ov[1], ov[2]};
               b.row    = 9'(2 * sp + sec);
               b.col    = 8'(col);
               b.second = (sec == 1);
               b.last   = (sec == 1) && (sp == H / 2 - 1) && (col == W / 2 - 1);
               q.push_back(b);
            end
            s_acc++;
         end
      end
   end

   typedef struct packed {
      logic signed [15:0] a, h, v, d;
      logic [7:0] e0, o0, e1, o1;
   } vec_t;

   vec_t vt [5];

   task automatic tick();
      @(posedge HCLK); #1;
   endtask

   task automatic rand_data();
      for (int c = 0; c < 3; c++) begin
         cA[c] = CW'($urandom); cH[c] = CW'($urandom);
         cV[c] = CW'($urandom); cD[c] = CW'($urandom);
      end
   endtask

   task automatic do_reset();
      HRESETn = 1'b0; in_valid = 1'b0;
      tick(); tick();
      HRESETn = 1'b1;
      tick();
   endtask

   // Holds in_valid until accepted; leaves the caller at posedge+1 of the accepting edge.
   task automatic wait_accept(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge HCLK); got = in_ready;
         @(posedge HCLK); #1;
      end
      chk(name, got, 1);
      in_valid = 1'b0;
   endtask

   task automatic send_vec(input vec_t t);
      for (int c = 0; c < 3; c++) begin
         cA[c] = CW'(t.a); cH[c] = CW'(t.h); cV[c] = CW'(t.v); cD[c] = CW'(t.d);
      end
      out_ready = 1'b1; in_valid = 1'b1;
      wait_accept("vec_accept");
      @(negedge HCLK);
      chk("vec_hsync0", HSYNC, 1);
      chk("vec_row0", dut_pix(), {t.e0, t.e0, t.e0, t.o0, t.o0, t.o0});
      @(negedge HCLK);
      chk("vec_row1_parity", out_row[0], 1);
      chk("vec_row1", dut_pix(), {t.e1, t.e1, t.e1, t.o1, t.o1, t.o1});
      tick();
   endtask

   task automatic run_random(input int ncyc, input int pv, input int pr);
      bit acc = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         if (acc || !in_valid) begin
            in_valid = ($urandom_range(99) < pv);
            rand_data();
         end
         out_ready = ($urandom_range(99) < pr);
         @(negedge HCLK); acc = in_valid && in_ready;
         @(posedge HCLK); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      int beats, first_cyc, last_cyc, sets_sent;
      bit acc, hit;
      int rows [8];
      int cols [8];
      int exp_rows [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int exp_cols [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

      vt[0] = '{a: 280, h: 40,   v: 80,  d: 0,  e0: 100, o0: 60, e1: 80, o1: 40};
      vt[1] = '{a: 0,   h: 0,    v: -40, d: 0,  e0: SAT ? 8'd0 : 8'd246, o0: 10,
                e1: SAT ? 8'd0 : 8'd246, o1: 10};
      vt[2] = '{a: 400, h: 0,    v: 0,   d: 0,  e0: 100, o0: 100, e1: 100, o1: 100};
      vt[3] = '{a: 511, h: -512, v: 0,   d: 0,  e0: SAT ? 8'd0 : 8'd255,
                o0: SAT ? 8'd0 : 8'd255, e1: 255, o1: 255};
      vt[4] = '{a: 100, h: -20,  v: -60, d: 40, e0: 15, o0: 25, e1: 5, o1: 55};
      for (int c = 0; c < 3; c++) begin
         cA[c] = '0; cH[c] = '0; cV[c] = '0; cD[c] = '0;
      end

      // Reset state
      repeat (3) tick();
      chk("reset_hsync", HSYNC, 0);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_pos", {out_row, out_col}, 0);
      HRESETn = 1'b1;
      tick();

      // Back-to-back over one full 4x4 frame
      out_ready = 1'b1; rand_data(); in_valid = 1'b1;
      beats = 0; sets_sent = 0; first_cyc = 0; last_cyc = 0;
      for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
         @(negedge HCLK);
         if (HSYNC) begin
            rows[beats] = out_row; cols[beats] = out_col;
            chk("b2b_in_ready", in_ready, beats % 2);
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
         end
         acc = in_valid && in_ready;
         @(posedge HCLK); #1;
         if (acc) begin
            sets_sent++;
            if (sets_sent == 4) in_valid = 1'b0; else rand_data();
         end
      end
      chk("b2b_beats", beats, 8);
      chk("b2b_continuous", last_cyc - first_cyc, 7);
      for (int i = 0; i < 8; i++) begin
         chk("frame_row", rows[i], exp_rows[i]);
         chk("frame_col", cols[i], exp_cols[i]);
      end
      @(negedge HCLK);
      chk("frame_done_pulse", frame_done, 1);
      chk("frame_wrap_pos", {out_row, out_col}, 0);
      @(negedge HCLK);
      chk("frame_done_once", frame_done, 0);
      tick();

      // Vector table
      for (int i = 0; i < 5; i++) send_vec(vt[i]);

      // Backpressure in BEAT0
      rand_data(); in_valid = 1'b1; out_ready = 1'b0;
      wait_accept("bp_accept");
      for (int k = 0; k < 5; k++) begin
         @(negedge HCLK);
         chk("bp_hsync", HSYNC, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_row_parity", out_row[0], 0);
         @(posedge HCLK); #1;
      end
      out_ready = 1'b1;
      @(negedge HCLK);
      chk("bp_release_beat0", {HSYNC, out_row[0]}, 2'b10);
      @(negedge HCLK);
      chk("bp_beat1", {HSYNC, out_row[0], in_ready}, 3'b111);
      @(negedge HCLK);
      chk("bp_idle", HSYNC, 0);
      tick();

      // Randomized traffic
      run_random(600, 70, 60);
      run_random(200, 100, 100);

      // Reset during BEAT1 of the third set
      do_reset();
      out_ready = 1'b1; rand_data(); in_valid = 1'b1;
      beats = 0; hit = 1'b0;
      for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
         @(negedge HCLK);
         if (HSYNC) begin
            if (beats == 5) begin
               hit = 1'b1;
               chk("pre_rst_pos", {out_row, out_col}, {9'd1, 8'd1});
               #2 HRESETn = 1'b0;
               #1;
               chk("midrst_hsync", HSYNC, 0);
               chk("midrst_pos", {out_row, out_col}, 0);
               chk("midrst_pix", dut_pix(), 0);
               chk("midrst_in_ready", in_ready, 0);
            end
            beats++;
         end
         acc = in_valid && in_ready;
         if (!hit) begin
            @(posedge HCLK); #1;
            if (acc) rand_data();
         end
      end
      chk("midrst_reached", hit, 1);
      in_valid = 1'b0;
      tick(); tick();
      HRESETn = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         cA[c] = CW'(280); cH[c] = CW'(40); cV[c] = CW'(80); cD[c] = CW'(0);
      end
      in_valid = 1'b1;
      wait_accept("post_rst_accept");
      @(negedge HCLK);
      chk("post_rst_pos", {HSYNC, out_row, out_col}, {1'b1, 9'd0, 8'd0});
      chk("post_rst_pix", {pe[0], po[0]}, {8'd100, 8'd60});
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
